// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: BCD digits, blink controls and the multiplexed segment drive.
// master sources digits/controls and observes the display lines; slave is the scan driver.
interface seg7_scan_driver_if;
    logic       tick_1hz;
    logic [3:0] Ht;
    logic [3:0] Hu;
    logic [3:0] Mt;
    logic [3:0] Mu;
    logic [3:0] blink_mask;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output tick_1hz, Ht, Hu, Mt, Mu, blink_mask,
        input  an, seg, dp
    );

    modport slave (
        input  tick_1hz, Ht, Hu, Mt, Mu, blink_mask,
        output an, seg, dp
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with anti-ghost blanking, hour leading-zero
// suppression, seconds dp blink and per-digit blink; outputs registered 1 clk behind state, no backpressure.
module seg7_scan_driver #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int BLANK_CYC  = 1000,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);
    localparam int DIV   = CLK_HZ / (REFRESH_HZ * 4);
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             phase_q, phase_d;
    logic [3:0]       cur_q, cur_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             lz_off;
    logic             blink_off;
    logic             digit_on;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        cur_d   = cur_q;
        phase_d = phase_q ^ bus.tick_1hz;

        // Digit for the upcoming slot is captured once, at the boundary
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
            case (idx_d)
                2'd0:    cur_d = bus.Mu;
                2'd1:    cur_d = bus.Mt;
                2'd2:    cur_d = bus.Hu;
                default: cur_d = bus.Ht;
            endcase
        end

        lz_off    = LZ_BLANK && (idx_q == 2'd3) && (cur_q == 4'd0);
        blink_off = bus.blink_mask[idx_q] && phase_q;
        digit_on  = (cnt_q >= BLANK_C) && !lz_off && !blink_off;

        an_d  = digit_on ? ~(4'b0001 << idx_q) : 4'b1111;
        seg_d = decode(cur_q);
        dp_d  = !(digit_on && (idx_q == 2'd2) && !phase_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            phase_q <= 1'b0;
            cur_q   <= 4'd0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            cur_q   <= cur_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: fixed scan/decode tables, directed corner sequences and
// randomized traffic against a slot-arithmetic reference model, on LZ_BLANK=1 and LZ_BLANK=0 instances.
module tb_seg7_scan_driver;
    localparam int CLK_HZ     = 400;
    localparam int REFRESH_HZ = 25;
    localparam int DIV        = CLK_HZ / (REFRESH_HZ * 4);
    localparam int BLANK      = 1;

    typedef struct { logic [3:0] val; logic [6:0] seg; } dec_vec_t;
    typedef struct { logic [3:0] an; logic [6:0] seg; logic dp; } scan_vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] ht, hu, mt, mu, mask;

    int total = 0;
    int bad   = 0;

    dec_vec_t  dec_tab  [16];
    scan_vec_t scan_tab [20];

    // Reference model: edges since reset, digit shown this slot, blink phase
    int         m_n;
    logic [3:0] m_cur;
    logic       m_phase;
    int         o_slot;

    seg7_scan_driver_if ifa ();
    seg7_scan_driver_if ifb ();

    assign ifa.tick_1hz = tick;  assign ifb.tick_1hz = tick;
    assign ifa.Ht = ht;          assign ifb.Ht = ht;
    assign ifa.Hu = hu;          assign ifb.Hu = hu;
    assign ifa.Mt = mt;          assign ifb.Mt = mt;
    assign ifa.Mu = mu;          assign ifb.Mu = mu;
    assign ifa.blink_mask = mask;
    assign ifb.blink_mask = mask;

    seg7_scan_driver #(.CLK_HZ(CLK_HZ), .REFRESH_HZ(REFRESH_HZ), .BLANK_CYC(BLANK), .LZ_BLANK(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    seg7_scan_driver #(.CLK_HZ(CLK_HZ), .REFRESH_HZ(REFRESH_HZ), .BLANK_CYC(BLANK), .LZ_BLANK(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] digit_of(input int d);
        case (d)
            0:       return mu;
            1:       return mt;
            2:       return hu;
            default: return ht;
        endcase
    endfunction

    // One clock: predict outputs from the model, advance, compare both instances
    task automatic step();
        logic [3:0] ea, eb;
        logic [6:0] es;
        logic       ed, on_a, on_b, blink;
        int         slot, pos, d;
        if (rst) begin
            ea = 4'hF; eb = 4'hF; es = 7'h7F; ed = 1'b1; o_slot = -1;
        end else begin
            slot  = m_n / DIV;
            pos   = m_n % DIV;
            d     = slot % 4;
            blink = mask[d] && m_phase;
            on_b  = (pos >= BLANK) && !blink;
            on_a  = on_b && !(d == 3 && m_cur == 4'd0);
            ea    = on_a ? ~(4'b0001 << d) : 4'hF;
            eb    = on_b ? ~(4'b0001 << d) : 4'hF;
            es    = dec_tab[m_cur].seg;
            ed    = !(on_a && d == 2 && !m_phase);
            o_slot = (pos == BLANK) ? d : -1;
        end
        @(posedge clk);
        if (rst) begin
            m_n = 0; m_cur = 4'd0; m_phase = 1'b0;
        end else begin
            m_n++;
            if (m_n % DIV == 0) m_cur = digit_of((m_n / DIV) % 4);
            if (tick) m_phase = !m_phase;
        end
        #1;
        chk("an_a", ifa.an, ea);
        chk("an_b", ifb.an, eb);
        chk("seg_a", ifa.seg, es);
        chk("seg_b", ifb.seg, es);
        chk("dp_a", ifa.dp, ed);
        chk("dp_b", ifb.dp, ed);
        chk("onehot_an_a", $countones(~ifa.an) <= 1, 1);
    endtask

    task automatic run_until_slot(input int d);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (o_slot != d && n < 40);
        chk("slot_reach", o_slot, d);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    initial begin
        logic hi_seen, an0_seen, an1_seen, an2_seen, an3_seen, dp_lo;
        int   first_k;

        for (int i = 0; i < 16; i++) dec_tab[i].val = 4'(i);
        dec_tab[0].seg  = 7'b1000000;  dec_tab[1].seg  = 7'b1111001;
        dec_tab[2].seg  = 7'b0100100;  dec_tab[3].seg  = 7'b0110000;
        dec_tab[4].seg  = 7'b0011001;  dec_tab[5].seg  = 7'b0010010;
        dec_tab[6].seg  = 7'b0000010;  dec_tab[7].seg  = 7'b1111000;
        dec_tab[8].seg  = 7'b0000000;  dec_tab[9].seg  = 7'b0010000;
        for (int i = 10; i < 16; i++) dec_tab[i].seg = 7'b0111111;

        // First 20 clocks after release with Ht..Mu = 1,2,3,4; first slot shows the reset latch (0)
        for (int k = 0; k < 20; k++) begin
            scan_tab[k].an = (k % 4 == 0) ? 4'hF : ~(4'b0001 << ((k / 4) % 4));
            scan_tab[k].dp = !((k / 4) == 2 && (k % 4) != 0);
        end
        for (int k = 0;  k < 4;  k++) scan_tab[k].seg = 7'b1000000;
        for (int k = 4;  k < 8;  k++) scan_tab[k].seg = 7'b0110000;
        for (int k = 8;  k < 12; k++) scan_tab[k].seg = 7'b0100100;
        for (int k = 12; k < 16; k++) scan_tab[k].seg = 7'b1111001;
        for (int k = 16; k < 20; k++) scan_tab[k].seg = 7'b0011001;

        m_n = 0; m_cur = 4'd0; m_phase = 1'b0; o_slot = -1;
        rst = 1'b1; tick = 1'b0; mask = 4'h0;
        ht = 4'd1; hu = 4'd2; mt = 4'd3; mu = 4'd4;
        repeat (3) step();
        chk("reset_an", ifa.an, 4'hF);
        chk("reset_seg", ifa.seg, 7'h7F);
        chk("reset_dp", ifa.dp, 1'b1);

        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("scan_tab_an", ifa.an, scan_tab[k].an);
            chk("scan_tab_seg", ifa.seg, scan_tab[k].seg);
            chk("scan_tab_dp", ifa.dp, scan_tab[k].dp);
        end

        for (int i = 0; i < 16; i++) begin
            mu = dec_tab[i].val;
            run_until_slot(1);
            run_until_slot(0);
            chk("decode_mu", ifa.seg, dec_tab[i].seg);
        end
        mu = 4'd4;

        // Hour leading zero
        ht = 4'd0; hu = 4'd9;
        run_until_slot(1);
        run_until_slot(2);
        chk("hu9_seg", ifa.seg, 7'b0010000);
        run_until_slot(3);
        chk("lz_an_a", ifa.an, 4'hF);
        chk("lz_an_b", ifb.an, 4'b0111);
        chk("lz_seg_b", ifb.seg, 7'b1000000);
        hi_seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (!ifa.an[3]) hi_seen = 1'b1;
        end
        chk("lz_an3_never", hi_seen, 1'b0);

        // Seconds blink on dp
        pulse_tick();
        dp_lo = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (!ifa.dp) dp_lo = 1'b1;
        end
        chk("dp_phase1_off", dp_lo, 1'b0);
        pulse_tick();
        run_until_slot(2);
        chk("dp_phase0_on", ifa.dp, 1'b0);

        // Blink mask on the hour digits
        ht = 4'd1; mask = 4'b1100;
        pulse_tick();
        hi_seen = 1'b0; an0_seen = 1'b0; an1_seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (!ifa.an[3] || !ifa.an[2]) hi_seen = 1'b1;
            if (!ifa.an[0]) an0_seen = 1'b1;
            if (!ifa.an[1]) an1_seen = 1'b1;
        end
        chk("blink_hours_off", hi_seen, 1'b0);
        chk("blink_mu_scans", an0_seen, 1'b1);
        chk("blink_mt_scans", an1_seen, 1'b1);
        pulse_tick();
        an0_seen = 1'b0; an1_seen = 1'b0; an2_seen = 1'b0; an3_seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (!ifa.an[0]) an0_seen = 1'b1;
            if (!ifa.an[1]) an1_seen = 1'b1;
            if (!ifa.an[2]) an2_seen = 1'b1;
            if (!ifa.an[3]) an3_seen = 1'b1;
        end
        chk("blink_all_scan", {an3_seen, an2_seen, an1_seen, an0_seen}, 4'b1111);
        mask = 4'h0;

        // Out-of-range digit and mid-slot change
        mu = 4'hB;
        run_until_slot(1);
        run_until_slot(0);
        chk("dash_seg", ifa.seg, 7'b0111111);
        mu = 4'd5;
        step();
        chk("midslot_hold", ifa.seg, 7'b0111111);
        run_until_slot(1);
        run_until_slot(0);
        chk("midslot_next", ifa.seg, 7'b0010010);

        // Reset during the Hu slot
        run_until_slot(2);
        step();
        rst = 1'b1;
        step();
        chk("midrst_an", ifa.an, 4'hF);
        chk("midrst_seg", ifa.seg, 7'h7F);
        chk("midrst_dp", ifa.dp, 1'b1);
        rst = 1'b0;
        first_k = -1;
        for (int k = 1; k <= 16 && first_k < 0; k++) begin
            step();
            if (ifa.an != 4'hF) begin
                first_k = k;
                chk("first_anode", ifa.an, 4'b1110);
            end
        end
        chk("first_anode_cycle", first_k, BLANK + 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) begin
                ht = 4'($urandom_range(15));
                hu = 4'($urandom_range(15));
                mt = 4'($urandom_range(15));
                mu = 4'($urandom_range(15));
            end
            if ($urandom_range(63) == 0) mask = 4'($urandom_range(15));
            tick = ($urandom_range(39) == 0);
            rst  = ($urandom_range(399) == 0);
            step();
        end
        tick = 1'b0;
        rst  = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
